// File: rtl/pio_led_out_blink_if.sv
// Avalon-MM slave register bus for the LED/strobe output port.
// The master drives address/strobes/write data; the slave returns registered read data.
interface pio_led_out_blink_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/pio_led_out_blink.sv
// Avalon-MM output port: DATA register with atomic set/clear, plus a per-bit
// hardware blink generator whose half-period is period+1 clocks.
module pio_led_out_blink #(
  parameter int unsigned WIDTH       = 8,
  parameter logic [31:0] RESET_VALUE = 32'h0,
  parameter int unsigned DIV_W       = 24
) (
  input  logic              clk,
  input  logic              reset_n,
  pio_led_out_blink_if.slave bus,
  output logic [WIDTH-1:0]  out_port
);

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_BLINK_EN = 3'd1;
  localparam logic [2:0] ADDR_PERIOD   = 3'd2;
  localparam logic [2:0] ADDR_STATUS   = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

  localparam logic [WIDTH-1:0] RST_DATA = RESET_VALUE[WIDTH-1:0];

  logic [WIDTH-1:0] data_reg;
  logic [WIDTH-1:0] blink_mask;
  logic [DIV_W-1:0] period;
  logic [DIV_W-1:0] cnt;
  logic             phase;

  logic             wr_en;
  logic             wr_data;
  logic             wr_blink;
  logic             wr_period;
  logic             wr_set;
  logic             wr_clr;
  logic             term_cnt;
  logic [WIDTH-1:0] wd_bits;
  logic [DIV_W-1:0] wd_period;
  logic [WIDTH-1:0] out_next;
  logic [31:0]      rd_next;
  logic             unused_wdata;

  // Write decode; addresses 3, 6 and 7 have no write effect.
  assign wr_en     = bus.chipselect & ~bus.write_n;
  assign wr_data   = wr_en & (bus.address == ADDR_DATA);
  assign wr_blink  = wr_en & (bus.address == ADDR_BLINK_EN);
  assign wr_period = wr_en & (bus.address == ADDR_PERIOD);
  assign wr_set    = wr_en & (bus.address == ADDR_OUTSET);
  assign wr_clr    = wr_en & (bus.address == ADDR_OUTCLEAR);

  assign wd_bits      = bus.writedata[WIDTH-1:0];
  assign wd_period    = bus.writedata[DIV_W-1:0];
  assign unused_wdata = ^{1'b0, bus.writedata};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_reg <= RST_DATA;
    end else if (wr_data) begin
      data_reg <= wd_bits;
    end else if (wr_set) begin
      data_reg <= data_reg | wd_bits;
    end else if (wr_clr) begin
      data_reg <= data_reg & ~wd_bits;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_mask <= '0;
    end else if (wr_blink) begin
      blink_mask <= wd_bits;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period <= '0;
    end else if (wr_period) begin
      period <= wd_period;
    end
  end

  // Blink timebase: a PERIOD write restarts a fresh high phase and wins over
  // the terminal count, so the new half-period starts cleanly from the write.
  assign term_cnt = (cnt == period);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (wr_period) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (term_cnt) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt   <= cnt + DIV_W'(1);
    end
  end

  assign out_next = data_reg & ~(blink_mask & {WIDTH{~phase}});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_port <= RST_DATA;
    end else begin
      out_port <= out_next;
    end
  end

  always_comb begin
    rd_next = 32'h0;
    case (bus.address)
      ADDR_DATA:     rd_next = 32'(data_reg);
      ADDR_BLINK_EN: rd_next = 32'(blink_mask);
      ADDR_PERIOD:   rd_next = 32'(period);
      ADDR_STATUS:   rd_next = {31'h0, phase};
      default:       rd_next = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.readdata <= 32'h0;
    end else begin
      bus.readdata <= rd_next;
    end
  end

endmodule

// File: tb/tb_pio_led_out_blink.sv
// Self-checking bench for pio_led_out_blink: directed test-plan steps plus a
// random phase, all compared against a register-level reference model.
module tb_pio_led_out_blink;

  logic       clk;
  logic       reset_n;
  logic [7:0] out_port;

  pio_led_out_blink_if bus_if ();

  pio_led_out_blink #(
    .WIDTH       (8),
    .RESET_VALUE (32'h3C),
    .DIV_W       (24)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus_if),
    .out_port (out_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: register contents plus edges elapsed since the blink
  // timebase was last restarted (reset release or PERIOD write).
  logic [7:0]  m_data;
  logic [7:0]  m_mask;
  logic [23:0] m_period;
  int unsigned m_ref;
  logic [7:0]  m_out;
  logic [31:0] m_rd;

  function automatic logic phase_of(input int unsigned k, input int unsigned p);
    return ((k / (p + 1)) % 2) == 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_data   = 8'h3C;
    m_mask   = 8'h00;
    m_period = 24'h0;
    m_ref    = 0;
    m_out    = 8'h3C;
    m_rd     = 32'h0;
  endtask

  task automatic drive(input logic cs, input logic wn, input logic [2:0] a, input logic [31:0] wd);
    bus_if.chipselect = cs;
    bus_if.write_n    = wn;
    bus_if.address    = a;
    bus_if.writedata  = wd;
  endtask

  task automatic idle(input logic [2:0] a);
    drive(1'b0, 1'b1, a, 32'h0);
  endtask

  // One clock edge: advance the model with pre-edge values, then compare.
  task automatic cycle();
    logic        ph;
    logic [7:0]  nout;
    logic [31:0] nrd;
    @(posedge clk);
    ph   = phase_of(m_ref, m_period);
    nout = m_data & ~(m_mask & ~{8{ph}});
    case (bus_if.address)
      3'd0:    nrd = {24'h0, m_data};
      3'd1:    nrd = {24'h0, m_mask};
      3'd2:    nrd = {8'h0, m_period};
      3'd3:    nrd = {31'h0, ph};
      default: nrd = 32'h0;
    endcase
    m_ref = m_ref + 1;
    if (bus_if.chipselect && !bus_if.write_n) begin
      case (bus_if.address)
        3'd0: m_data = bus_if.writedata[7:0];
        3'd1: m_mask = bus_if.writedata[7:0];
        3'd2: begin m_period = bus_if.writedata[23:0]; m_ref = 0; end
        3'd4: m_data = m_data | bus_if.writedata[7:0];
        3'd5: m_data = m_data & ~bus_if.writedata[7:0];
        default: ;
      endcase
    end
    m_out = nout;
    m_rd  = nrd;
    #1;
    check("out_port", {24'h0, out_port}, {24'h0, m_out});
    check("readdata", bus_if.readdata, m_rd);
  endtask

  task automatic write(input logic [2:0] a, input logic [31:0] wd, input logic [2:0] next_a);
    drive(1'b1, 1'b0, a, wd);
    cycle();
    idle(next_a);
  endtask

  initial begin
    int waited;
    logic [2:0]  ra;
    logic [31:0] rw;

    // Reset check
    reset_n = 1'b0;
    idle(3'd3);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_port", {24'h0, out_port}, 32'h3C);
    check("rst_readdata", bus_if.readdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    cycle();
    check("rst_status", bus_if.readdata, 32'h1);
    idle(3'd1);
    cycle();
    check("rst_blink_en", bus_if.readdata, 32'h0);

    // Data path
    write(3'd0, 32'h0000_00A5, 3'd0);
    cycle();
    check("data_out", {24'h0, out_port}, 32'hA5);
    check("data_read", bus_if.readdata, 32'hA5);

    // Atomic set / clear
    write(3'd4, 32'h0000_000F, 3'd4);
    cycle();
    check("outset_out", {24'h0, out_port}, 32'hAF);
    check("outset_read", bus_if.readdata, 32'h0);
    write(3'd5, 32'h0000_0081, 3'd5);
    cycle();
    check("outclr_out", {24'h0, out_port}, 32'h2E);
    check("outclr_read", bus_if.readdata, 32'h0);

    // Blink with PERIOD=3: 4 clocks high, 4 clocks low
    write(3'd0, 32'h0000_00FF, 3'd0);
    write(3'd1, 32'h0000_0001, 3'd1);
    write(3'd2, 32'h0000_0003, 3'd3);
    for (int i = 1; i <= 16; i++) begin
      cycle();
      check("blink_bit0", {31'h0, out_port[0]}, {31'h0, (((i - 1) / 4) % 2) == 0});
      check("blink_upper", {25'h0, out_port[7:1]}, 32'h7F);
      check("blink_status", {31'h0, bus_if.readdata[0]}, {31'h0, out_port[0]});
    end

    // Period rewrite mid low phase
    waited = 0;
    while (!(phase_of(m_ref, m_period) == 1'b0 && (m_ref % 4) == 2) && waited < 20) begin
      cycle();
      waited++;
    end
    check("wait_low_phase", {31'h0, waited < 20}, 32'h1);
    write(3'd2, 32'h0000_0009, 3'd3);
    for (int i = 1; i <= 12; i++) begin
      cycle();
      check("rewrite_bit0", {31'h0, out_port[0]}, {31'h0, i <= 10});
      check("rewrite_status", bus_if.readdata, {31'h0, i <= 10});
    end

    // Ignored writes
    drive(1'b0, 1'b0, 3'd0, 32'h0000_0000);
    cycle();
    idle(3'd0);
    cycle();
    check("nocs_data", bus_if.readdata, 32'hFF);
    write(3'd6, 32'hFFFF_FFFF, 3'd6);
    cycle();
    check("addr6_read", bus_if.readdata, 32'h0);
    idle(3'd1);
    cycle();
    check("addr6_mask", bus_if.readdata, 32'h01);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      ra = 3'($urandom_range(0, 7));
      rw = $urandom;
      if (ra == 3'd2) rw = rw & 32'hFF00_0007;
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, rw);
      cycle();
    end

    // Reset mid-blink
    write(3'd0, 32'h0000_00F0, 3'd3);
    write(3'd1, 32'h0000_00FF, 3'd3);
    write(3'd2, 32'h0000_0002, 3'd3);
    repeat (5) cycle();
    #3;
    reset_n = 1'b0;
    #1;
    check("midrst_out", {24'h0, out_port}, 32'h3C);
    check("midrst_read", bus_if.readdata, 32'h0);
    model_reset();
    idle(3'd2);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    cycle();
    check("midrst_period", bus_if.readdata, 32'h0);
    idle(3'd1);
    cycle();
    check("midrst_mask", bus_if.readdata, 32'h0);
    idle(3'd0);
    cycle();
    check("midrst_data", bus_if.readdata, 32'h3C);
    check("midrst_pins", {24'h0, out_port}, 32'h3C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pio_led_out_blink.md
# pio_led_out_blink

Avalon-MM slave output port that drives a WIDTH-bit board output bus (LEDs, strobes) from processor-written registers. It is the write-side counterpart of the DIP-switch input port and sits on the same Qsys system interconnect. It adds atomic bit-set/bit-clear registers and a per-bit hardware blink generator with a programmable half-period. Blinking therefore needs no CPU involvement after setup.

## Interface
Parameters:
- WIDTH, 8, width of out_port and of the DATA/BLINK_EN registers (1..32)
- RESET_VALUE, 0, value loaded into DATA at reset
- DIV_W, 24, width of the blink half-period register and counter (1..32)

Ports:
- clk  input  1  system clock; all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- address  input  3  word address of register
- chipselect  input  1  slave select
- write_n  input  1  active-low write strobe; write occurs when chipselect=1 and write_n=0
- writedata  input  32  write data
- readdata  output  32  registered read data
- out_port  output  WIDTH  registered output bus

## Operation
- Register map (word addresses):
  - 0 DATA, RW: data_reg[WIDTH-1:0]
  - 1 BLINK_EN, RW: blink_mask[WIDTH-1:0]
  - 2 PERIOD, RW: period[DIV_W-1:0]; half-period = period+1 clocks
  - 3 STATUS, RO: bit0 = phase; other bits 0
  - 4 OUTSET, WO: data_reg <= data_reg | writedata[WIDTH-1:0]
  - 5 OUTCLEAR, WO: data_reg <= data_reg & ~writedata[WIDTH-1:0]
  - 6, 7: reserved; writes ignored, read 0
- Write-only registers read as 0. Bits above WIDTH/DIV_W are ignored on write and read as 0.
- Blink generator:
  - cnt[DIV_W-1:0] increments every clk.
  - When cnt == period: cnt <= 0 and phase toggles.
  - A write to PERIOD forces cnt <= 0 and phase <= 1 in the same edge. This override has priority over the terminal count.
  - period = 0 means phase toggles every clock.
- Output function: out_next = data_reg & ~(blink_mask & {WIDTH{~phase}}).
  - Blinking bits follow data_reg AND phase.
  - Non-blinking bits follow data_reg.
- Writes to BLINK_EN do not disturb cnt or phase.
- Reads:
  - readdata is recomputed from address on every clock, independent of chipselect and write_n.
  - No read side effects.

## Timing
- Reset (asynchronous assert, synchronous release by clk):
  - data_reg = RESET_VALUE
  - blink_mask = 0
  - period = 0
  - cnt = 0
  - phase = 1
  - out_port = RESET_VALUE[WIDTH-1:0]
  - readdata = 0
- Write accepted at edge N (register updated at N). out_port reflects it at edge N+1, a one-cycle write-to-pin latency.
- Read latency: 1 clock. readdata at edge N+1 reflects address and register contents sampled at edge N.
- phase toggles at edge N; out_port reflects the toggle at edge N+1.
- Blink square wave: each phase lasts exactly period+1 clocks. A full cycle is 2*(period+1) clocks.
- Reset mid-blink: all state returns to reset values immediately; no partial phase is retained.
- Only one write per cycle (Avalon), so set/clear/data conflicts cannot occur.

## Test plan
- Reset check: assert reset_n=0 with RESET_VALUE=8'h3C, then release.
  - Required: out_port=8'h3C, readdata=0, STATUS=1, BLINK_EN=0.
- Data path: write DATA=0xA5 at edge N.
  - Required: out_port=0xA5 at N+1.
  - Required: read addr 0 returns 0x000000A5 one clock after address is presented.
- Atomic bit ops: write OUTSET=0x0F on DATA=0xA5, then OUTCLEAR=0x81.
  - Required: out_port 0xAF, then 0x2E.
  - Required: reads of addr 4 and 5 return 0.
- Blink: DATA=0xFF, BLINK_EN=0x01, PERIOD=3.
  - Required: out_port bit0 high 4 clocks, low 4 clocks, repeating.
  - Required: bits 7:1 stay 1; STATUS bit0 tracks phase.
- Period rewrite: write PERIOD=9 mid-phase while phase=0.
  - Required: phase=1 and cnt=0 at the write edge; next toggle exactly 10 clocks later.
- Ignored writes: write_n=0 with chipselect=0 to DATA; write to address 6; assert reset_n mid-blink.
  - Required: no register change on the ignored writes.
  - Required: reset restores all reset values immediately.
